// File: rtl/sevenseg_scan_pwm_if.sv
// Display bundle between the application logic and the scanned 7-segment controller.
// The master side supplies the characters and display controls; the slave side drives the pins.
interface sevenseg_scan_pwm_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [5*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [3:0]              brightness;
    logic                    enable;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    scan_tick;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output digits, dp, blink_en, brightness, enable,
        input  seg, an, scan_tick, digit_idx
    );

    modport slave (
        input  digits, dp, blink_en, brightness, enable,
        output seg, an, scan_tick, digit_idx
    );
endinterface

// File: rtl/sevenseg_scan_pwm.sv
// Multiplexed 7-segment scanner with a blanking gap at the start of every slot,
// 16-level PWM brightness inside the remaining window and per-digit blinking.
// The character, decimal point and brightness are captured once per slot.
// Anodes and cathodes leave through registers.
module sevenseg_scan_pwm #(
    parameter int NUM_DIGITS           = 8,
    parameter int CLK_FREQUENCY_HZ     = 100000000,
    parameter int REFRESH_FREQUENCY_HZ = 500,
    parameter int BLANK_CYCLES         = 16,
    parameter int BLINK_DIV            = 50,
    parameter int ANODE_ACTIVE_LOW     = 1,
    parameter int SEG_ACTIVE_LOW       = 1,
    parameter int SIMULATE             = 0,
    parameter int SIMULATE_SLOT_LEN    = 40
) (
    input logic               clk,
    input logic               reset,
    sevenseg_scan_pwm_if.slave disp
);
    localparam int SLOT_LEN = (SIMULATE != 0) ? SIMULATE_SLOT_LEN
                                              : CLK_FREQUENCY_HZ / REFRESH_FREQUENCY_HZ;
    localparam int WIN      = SLOT_LEN - BLANK_CYCLES;
    localparam int CNT_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int MUL_W    = $clog2(WIN) + 5;
    // Shared width for slot position vs. window edges, with headroom for the sum.
    localparam int CMP_W    = ((MUL_W > CNT_W) ? MUL_W : CNT_W) + 1;

    localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(SLOT_LEN - 1);
    localparam logic [IDX_W-1:0]      DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]     SCAN_LAST  = SCAN_W'(BLINK_DIV - 1);
    localparam logic [MUL_W-1:0]      WIN_M      = MUL_W'(WIN);
    localparam logic [CMP_W-1:0]      WIN_LO     = CMP_W'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                           : {NUM_DIGITS{1'b0}};
    localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Character generator, bits g..a, 1 = segment lit.
    function automatic logic [6:0] decode_char(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'd0:    pat = 7'h3F;
            5'd1:    pat = 7'h06;
            5'd2:    pat = 7'h5B;
            5'd3:    pat = 7'h4F;
            5'd4:    pat = 7'h66;
            5'd5:    pat = 7'h6D;
            5'd6:    pat = 7'h7D;
            5'd7:    pat = 7'h07;
            5'd8:    pat = 7'h7F;
            5'd9:    pat = 7'h6F;
            5'd10:   pat = 7'h77;
            5'd11:   pat = 7'h7C;
            5'd12:   pat = 7'h39;
            5'd13:   pat = 7'h5E;
            5'd14:   pat = 7'h79;
            5'd15:   pat = 7'h71;
            5'd16:   pat = 7'h01;
            5'd17:   pat = 7'h02;
            5'd18:   pat = 7'h04;
            5'd19:   pat = 7'h08;
            5'd20:   pat = 7'h10;
            5'd21:   pat = 7'h20;
            5'd22:   pat = 7'h40;
            5'd24:   pat = 7'h76;
            5'd25:   pat = 7'h38;
            5'd26:   pat = 7'h77;
            5'd27:   pat = 7'h30;
            5'd28:   pat = 7'h50;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0]      slot_cnt_q,    slot_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q,   digit_idx_d;
    logic [SCAN_W-1:0]     scan_cnt_q,    scan_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [4:0]            cur_code_q,    cur_code_d;
    logic                  cur_dp_q,      cur_dp_d;
    logic [MUL_W-1:0]      on_len_q,      on_len_d;
    logic [NUM_DIGITS-1:0] an_q,          an_d;
    logic [7:0]            seg_q,         seg_d;
    logic                  scan_tick_q,   scan_tick_d;

    logic                  slot_start_s;
    logic                  slot_wrap_s;
    logic                  digit_wrap_s;
    logic [4:0]            code_sel_s;
    logic                  dp_sel_s;
    logic [MUL_W-1:0]      prod_s;
    logic [MUL_W-1:0]      on_len_sel_s;
    logic [CMP_W-1:0]      slot_ext_s;
    logic [CMP_W-1:0]      win_hi_s;
    logic                  lit_s;
    logic [NUM_DIGITS-1:0] an_int_s;
    logic [7:0]            seg_int_s;

    // Counter chain: slot position, digit index, scan count and blink phase.
    always_comb begin
        slot_wrap_s   = (slot_cnt_q == SLOT_LAST);
        digit_wrap_s  = slot_wrap_s && (digit_idx_q == DIGIT_LAST);
        slot_cnt_d    = slot_cnt_q + CNT_W'(1);
        digit_idx_d   = digit_idx_q;
        scan_cnt_d    = scan_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_wrap_s) begin
            slot_cnt_d = '0;
            if (digit_wrap_s) begin
                digit_idx_d = '0;
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d    = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end else begin
                digit_idx_d = digit_idx_q + IDX_W'(1);
            end
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
    end

    // Slot-start capture; the freshly sampled values are forwarded within the capture cycle.
    always_comb begin
        slot_start_s = (slot_cnt_q == '0);
        prod_s       = WIN_M * MUL_W'({1'b0, disp.brightness} + 5'd1);
        if (slot_start_s) begin
            code_sel_s   = disp.digits[5*digit_idx_q +: 5];
            dp_sel_s     = disp.dp[digit_idx_q];
            on_len_sel_s = prod_s >> 4;
        end else begin
            code_sel_s   = cur_code_q;
            dp_sel_s     = cur_dp_q;
            on_len_sel_s = on_len_q;
        end
        cur_code_d = code_sel_s;
        cur_dp_d   = dp_sel_s;
        on_len_d   = on_len_sel_s;
    end

    // Lit window, anode/cathode patterns and output polarity.
    always_comb begin
        slot_ext_s = CMP_W'(slot_cnt_q);
        win_hi_s   = WIN_LO + CMP_W'(on_len_sel_s);
        lit_s      = disp.enable && (slot_ext_s >= WIN_LO) && (slot_ext_s < win_hi_s)
                     && !(disp.blink_en[digit_idx_q] && blink_phase_q);
        an_int_s   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_int_s[i] = lit_s && (digit_idx_q == IDX_W'(i));
        end
        seg_int_s   = {dp_sel_s, decode_char(code_sel_s)};
        an_d        = (ANODE_ACTIVE_LOW != 0) ? ~an_int_s : an_int_s;
        seg_d       = (SEG_ACTIVE_LOW != 0) ? ~seg_int_s : seg_int_s;
        scan_tick_d = digit_wrap_s;
    end

    // State and output registers; reset aborts any slot in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            scan_cnt_q    <= '0;
            blink_phase_q <= 1'b0;
            cur_code_q    <= 5'd0;
            cur_dp_q      <= 1'b0;
            on_len_q      <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            scan_tick_q   <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            scan_cnt_q    <= scan_cnt_d;
            blink_phase_q <= blink_phase_d;
            cur_code_q    <= cur_code_d;
            cur_dp_q      <= cur_dp_d;
            on_len_q      <= on_len_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            scan_tick_q   <= scan_tick_d;
        end
    end

    assign disp.an        = an_q;
    assign disp.seg       = seg_q;
    assign disp.scan_tick = scan_tick_q;
    assign disp.digit_idx = digit_idx_q;
endmodule

// File: doc/sevenseg_scan_pwm.md
Name: sevenseg_scan_pwm

Overview:
Parametrised multiplexed 7-segment display controller and the successor to the fixed 8-digit controller. It scans NUM_DIGITS digits, decodes one 5-bit character code per digit, and adds three features:
- per-slot ghost-suppression blanking;
- 16-level PWM brightness;
- per-digit blinking.
Anode and cathode polarity are configurable. It sits between the application logic and the board's display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
CLK_FREQUENCY_HZ, 100000000, clk frequency
REFRESH_FREQUENCY_HZ, 500, per-digit slot rate
BLANK_CYCLES, 16, anode-off cycles at start of each slot; must be < SLOT_LEN
BLINK_DIV, 50, full scans per blink half-period
ANODE_ACTIVE_LOW, 1, 1 = anodes driven low when on
SEG_ACTIVE_LOW, 1, 1 = cathodes driven low when lit
SIMULATE, 0, 1 = use SIMULATE_SLOT_LEN
SIMULATE_SLOT_LEN, 40, slot length in clocks when SIMULATE=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
digits  in  5*NUM_DIGITS  character codes; digit i = digits[5i+4:5i]
dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
blink_en  in  NUM_DIGITS  1 = digit i blinks
brightness  in  4  0 = dimmest, 15 = full
enable  in  1  0 = all anodes off
seg  out  8  cathodes; seg[7]=dp, seg[6:0]=g..a
an  out  NUM_DIGITS  anodes; an[i] drives digit i
scan_tick  out  1  one-cycle pulse at end of each full scan
digit_idx  out  max(1,$clog2(NUM_DIGITS))  digit currently scanned

Behaviour:
- Slot length:
  - SLOT_LEN = SIMULATE ? SIMULATE_SLOT_LEN : CLK_FREQUENCY_HZ/REFRESH_FREQUENCY_HZ.
  - WIN = SLOT_LEN − BLANK_CYCLES.
- Counters:
  - slot_cnt counts 0..SLOT_LEN−1 and wraps.
  - At wrap, digit_idx increments modulo NUM_DIGITS.
  - When digit_idx wraps from NUM_DIGITS−1 to 0, scan_cnt increments.
  - When scan_cnt reaches BLINK_DIV−1, scan_cnt returns to 0 and blink_phase toggles.
- scan_tick is asserted in the same cycle that digit_idx wraps from NUM_DIGITS−1 to 0.
- Capture:
  - In the cycle slot_cnt==0, the code and dp of digit digit_idx are latched into cur_code and cur_dp.
  - Input changes mid-slot have no effect until that digit's next slot.
- PWM on-length:
  - on_len = (WIN*(brightness+1))>>4.
  - brightness is sampled at slot start together with the code.
- Lit condition: lit = enable && BLANK_CYCLES ≤ slot_cnt < BLANK_CYCLES+on_len && !(blink_en[digit_idx] && blink_phase).
- Outputs are registered, so an and seg reflect the counter state of the previous cycle:
  - an: bit digit_idx = lit; all other bits off. Polarity inverted if ANODE_ACTIVE_LOW.
  - seg: {cur_dp, decode(cur_code)}, with 1 = lit internally. Polarity inverted if SEG_ACTIVE_LOW.
  - seg is driven continuously; anode gating alone blanks the display.
- Decode table (internal bits g..a, 1 = lit):

  | Codes | Characters | Internal pattern(s) |
  |---|---|---|
  | 0-9 | digits 0-9 | 0x3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F |
  | 10-15 | A b C d E F | 77, 7C, 39, 5E, 79, 71 |
  | 16-22 | single segment a..g | — |
  | 24 | H | 76 |
  | 25 | L | 38 |
  | 26 | R | 77 |
  | 27 | l | 30 |
  | 28 | r | 50 |
  | 23, 29-31 | blank | 00 |

- enable=0: counters and scan_tick keep running; all anodes are off.
- Reset, checked before any other update:
  - slot_cnt, digit_idx, scan_cnt, blink_phase, cur_code and cur_dp = 0.
  - scan_tick = 0.
  - an = all off at the configured polarity; seg = all unlit.
  - Reset asserted mid-slot aborts the slot. After reset release, the first slot is digit 0, starting at slot_cnt = 0.
- Sizing rules:
  - on_len arithmetic uses width clog2(WIN)+5; no overflow.
  - brightness = 15 gives on_len = WIN.
  - brightness = 0 gives on_len = WIN>>4, which may be 0, meaning the digit is never lit.

Test Plan:
All scenarios use SIMULATE=1, SIMULATE_SLOT_LEN=40, BLANK_CYCLES=4, NUM_DIGITS=4, BLINK_DIV=2, active-low polarity, so WIN=36.
1. Basic scan:
   - Stimulus: reset, then digits codes {3,2,1,0} for digits 3..0, dp=0, brightness=15, enable=1, blink_en=0.
   - Response: an sequences 1110, 1101, 1011, 0111; each pattern is held 36 of every 40 clocks, with 1111 for 4 clocks at each slot start. During digit 1, seg=8'hF9.
   - scan_tick pulses once every 160 clocks.
2. Brightness:
   - brightness=7 → 18 anode-on clocks per slot.
   - brightness=0 → 2 anode-on clocks per slot.
   - Each slot is measured on digit 0.
3. Blink:
   - Stimulus: blink_en=4'b0010.
   - Response: an[1] is low for 18 clocks per digit-1 slot during scans 0-1, stays high for all of scans 2-3, and the pattern repeats. Other digits are unaffected.
4. Mid-slot change:
   - Stimulus: change digit 0 code from 8 to 23 at slot_cnt=10 of digit 0's slot.
   - Response: seg stays 8'h80 for the rest of the slot; seg=8'hFF in digit 0's next slot.
5. Reset mid-slot:
   - Stimulus: assert reset at digit 2, slot_cnt=20.
   - Response: next cycle an=1111, seg=FF, digit_idx=0, scan_tick=0. After release, digit 0's anode first goes low 5 clocks later.
6. Enable and odd codes:
   - enable=0 → an=1111 continuously while scan_tick still pulses every 160 clocks.
   - With enable=1, code 24 with dp=1 → seg=8'h09.
